// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared types and widths for the customer-session sequencer in front of the
// vending core.
//   CREDIT_W     : width of credit, coin values, money and change (core width)
//   CODE_W       : width of the product code
//   NUM_PRODUCTS : number of real products; codes at or above it are passed to
//                  the core untouched and come back as out-of-stock
//   vend_state_e : session state, also exported on the debug port
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int CREDIT_W     = 4;
    localparam int CODE_W       = 3;
    localparam int NUM_PRODUCTS = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,  // no credit held
        ST_CREDIT = 3'd1,  // credit held, waiting for the customer
        ST_ISSUE  = 3'd2,  // request presented to the core
        ST_WAIT   = 3'd3,  // core result sampled
        ST_REFUND = 3'd4   // coins returned
    } vend_state_e;

    // States in which the customer cannot interact with the session.
    function automatic logic is_busy_state(vend_state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_REFUND);
    endfunction

endpackage

// File: rtl/vend_session_ctrl_if.sv
// -----------------------------------------------------------------------------
// vend_session_ctrl_if
// Bus between the session sequencer (master) and the vending core (slave).
//   core_money    : master -> core, money presented; 0 means "no request"
//   core_code     : master -> core, product code
//   core_dispense : core -> master, registered dispense flag
//   core_change   : core -> master, registered change amount
//   core_oos      : core -> master, registered out-of-stock flag
//
// Request semantics: a request is exactly the one cycle in which core_money is
// non-zero; there is no ready/back-pressure, the core always samples. The core
// answers on its registered outputs in the following cycle, and only that
// cycle's values belong to the request. With core_money at 0 the core takes no
// action, so stock never moves outside an issued request.
// -----------------------------------------------------------------------------
interface vend_session_ctrl_if;
    import vend_pkg::*;

    logic [CREDIT_W-1:0] core_money;
    logic [CODE_W-1:0]   core_code;
    logic                core_dispense;
    logic [CREDIT_W-1:0] core_change;
    logic                core_oos;

    modport master (
        output core_money,
        output core_code,
        input  core_dispense,
        input  core_change,
        input  core_oos
    );

    modport slave (
        input  core_money,
        input  core_code,
        output core_dispense,
        output core_change,
        output core_oos
    );

endinterface

// File: rtl/vend_timeout_timer.sv
// -----------------------------------------------------------------------------
// vend_timeout_timer
// Inactivity counter for a session holding credit.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force count to 0 (has priority over enable)
//   enable     : count one per cycle
//   tc         : terminal count, high while count == TIMEOUT_CYCLES-1
// The count holds at the terminal value; the owner leaves the counting state
// or clears the timer in that cycle.
// -----------------------------------------------------------------------------
module vend_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vend_session_ctrl.sv
// -----------------------------------------------------------------------------
// vend_session_ctrl
// Customer-session sequencer in front of the vending core: accumulates coin
// credit, latches the selection, issues a one-cycle request to the core,
// samples its registered result and reports the outcome, returning change or
// refunding on cancel / inactivity timeout.
//   clk, reset         : clock, asynchronous active-high reset
//   coin_valid/value   : one-cycle coin strobe and value
//   sel_valid/code     : one-cycle product select strobe and code
//   cancel             : one-cycle refund request
//   core               : bus to the vending core (master side)
//   credit             : current credit
//   busy               : high in ISSUE, WAIT, REFUND
//   vend_done          : strobe, product dispensed
//   vend_fail          : strobe, out of stock / bad code / short credit
//   refund_valid/amount: strobe with coins returned (amount 0 otherwise)
//   coin_reject        : strobe, coin not accepted
//   state_dbg          : current session state
// All outputs are registered. Credit held when reset hits is lost.
// -----------------------------------------------------------------------------
module vend_session_ctrl
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CREDIT_MAX     = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [CREDIT_W-1:0]  coin_value,
    input  logic                 sel_valid,
    input  logic [CODE_W-1:0]    sel_code,
    input  logic                 cancel,
    vend_session_ctrl_if.master  core,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy,
    output logic                 vend_done,
    output logic                 vend_fail,
    output logic                 refund_valid,
    output logic [CREDIT_W-1:0]  refund_amount,
    output logic                 coin_reject,
    output vend_state_e          state_dbg
);

    localparam logic [CREDIT_W:0] SUM_MAX = (CREDIT_W + 1)'(CREDIT_MAX);

    vend_state_e         state_q,         state_d;
    logic [CREDIT_W-1:0] credit_q,        credit_d;
    logic [CODE_W-1:0]   code_q,          code_d;
    logic [CREDIT_W-1:0] core_money_q,    core_money_d;
    logic                busy_q,          busy_d;
    logic                vend_done_q,     vend_done_d;
    logic                vend_fail_q,     vend_fail_d;
    logic                refund_valid_q,  refund_valid_d;
    logic [CREDIT_W-1:0] refund_amount_q, refund_amount_d;
    logic                coin_reject_q,   coin_reject_d;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                timer_clear;
    logic                timer_en;
    logic                timer_tc;

    // One extra bit so an overflowing coin is seen rather than wrapping.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_fits = (coin_sum <= SUM_MAX);

    vend_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        code_d          = code_q;
        core_money_d    = '0;
        vend_done_d     = 1'b0;
        vend_fail_d     = 1'b0;
        refund_valid_d  = 1'b0;
        refund_amount_d = '0;
        coin_reject_d   = 1'b0;
        // The timer only runs while credit waits on the customer.
        timer_clear     = 1'b1;
        timer_en        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // sel_valid and cancel mean nothing without credit.
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        // A zero-value coin is a no-op; stay without credit.
                        if (coin_sum != '0) begin
                            state_d = ST_CREDIT;
                        end
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_CREDIT: begin
                timer_clear = 1'b0;
                timer_en    = 1'b1;
                if (cancel) begin
                    state_d         = ST_REFUND;
                    refund_valid_d  = 1'b1;
                    refund_amount_d = credit_q;
                    coin_reject_d   = coin_valid;
                end else if (sel_valid) begin
                    state_d       = ST_ISSUE;
                    code_d        = sel_code;
                    core_money_d  = credit_q;
                    coin_reject_d = coin_valid;
                    timer_clear   = 1'b1;
                end else if (coin_valid && coin_fits) begin
                    credit_d    = coin_sum[CREDIT_W-1:0];
                    timer_clear = 1'b1;
                end else begin
                    // A rejected coin is not activity; the timeout still runs.
                    coin_reject_d = coin_valid;
                    if (timer_tc) begin
                        state_d         = ST_REFUND;
                        refund_valid_d  = 1'b1;
                        refund_amount_d = credit_q;
                    end
                end
            end

            ST_ISSUE: begin
                // Request is live this cycle only; money returns to 0 next.
                coin_reject_d = coin_valid;
                state_d       = ST_WAIT;
            end

            ST_WAIT: begin
                coin_reject_d = coin_valid;
                if (core.core_dispense) begin
                    vend_done_d = 1'b1;
                    credit_d    = '0;
                    state_d     = ST_IDLE;
                    if (core.core_change != '0) begin
                        refund_valid_d  = 1'b1;
                        refund_amount_d = core.core_change;
                    end
                end else if (core.core_oos || !core.core_dispense) begin
                    // Out of stock, invalid code, or a silent core (short
                    // credit): keep the credit and hand control back.
                    vend_fail_d = 1'b1;
                    state_d     = ST_CREDIT;
                end
            end

            ST_REFUND: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase

        busy_d = is_busy_state(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            credit_q        <= '0;
            code_q          <= '0;
            core_money_q    <= '0;
            busy_q          <= 1'b0;
            vend_done_q     <= 1'b0;
            vend_fail_q     <= 1'b0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= '0;
            coin_reject_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            code_q          <= code_d;
            core_money_q    <= core_money_d;
            busy_q          <= busy_d;
            vend_done_q     <= vend_done_d;
            vend_fail_q     <= vend_fail_d;
            refund_valid_q  <= refund_valid_d;
            refund_amount_q <= refund_amount_d;
            coin_reject_q   <= coin_reject_d;
        end
    end

    assign core.core_money = core_money_q;
    assign core.core_code  = code_q;
    assign credit          = credit_q;
    assign busy            = busy_q;
    assign vend_done       = vend_done_q;
    assign vend_fail       = vend_fail_q;
    assign refund_valid    = refund_valid_q;
    assign refund_amount   = refund_amount_q;
    assign coin_reject     = coin_reject_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_session_ctrl
// Directed scenarios followed by a random session mix. A simple vending core
// stand-in answers requests; expectations come from a transaction-level model
// (credit arithmetic plus a price/stock table).
// -----------------------------------------------------------------------------
module tb_vend_session_ctrl;
    import vend_pkg::*;

    localparam int TMO  = 8;
    localparam int CMAX = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_value;
    logic                sel_valid;
    logic [CODE_W-1:0]   sel_code;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                vend_done;
    logic                vend_fail;
    logic                refund_valid;
    logic [CREDIT_W-1:0] refund_amount;
    logic                coin_reject;
    vend_state_e         state_dbg;

    vend_session_ctrl_if core_if();

    vend_session_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .CREDIT_MAX     (CMAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .sel_valid     (sel_valid),
        .sel_code      (sel_code),
        .cancel        (cancel),
        .core          (core_if),
        .credit        (credit),
        .busy          (busy),
        .vend_done     (vend_done),
        .vend_fail     (vend_fail),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .coin_reject   (coin_reject),
        .state_dbg     (state_dbg)
    );

    // ---------------- vending core stand-in ----------------
    int price [6] = '{15, 5, 10, 7, 3, 12};
    int core_stock [6] = '{5, 0, 3, 4, 2, 1};
    int   core_idx;
    logic core_bad;
    assign core_bad = (core_if.core_code >= 3'd6);
    assign core_idx = core_bad ? 0 : int'(core_if.core_code);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_if.core_dispense <= 1'b0;
            core_if.core_change   <= '0;
            core_if.core_oos      <= 1'b0;
        end else begin
            core_if.core_dispense <= 1'b0;
            core_if.core_change   <= '0;
            core_if.core_oos      <= 1'b0;
            if (core_if.core_money != '0) begin
                if (core_bad || core_stock[core_idx] == 0) begin
                    core_if.core_oos <= 1'b1;
                end else if (int'(core_if.core_money) >= price[core_idx]) begin
                    core_if.core_dispense <= 1'b1;
                    core_if.core_change   <= 4'(int'(core_if.core_money) - price[core_idx]);
                    core_stock[core_idx]  <= core_stock[core_idx] - 1;
                end
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    int m_credit = 0;
    int m_stock [6] = '{5, 0, 3, 4, 2, 1};
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0;
        coin_value = '0;
        sel_valid  = 1'b0;
        sel_code   = '0;
        cancel     = 1'b0;
    endtask

    task automatic do_coin(input int v);
        bit ok;
        coin_valid = 1'b1;
        coin_value = 4'(v);
        tick();
        idle_inputs();
        ok = (m_credit + v) <= CMAX;
        if (ok) m_credit = m_credit + v;
        chk("coin_reject", 32'(coin_reject), 32'(!ok));
        chk("coin_credit", 32'(credit), 32'(m_credit));
        chk("coin_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_select(input int code, input bit with_coin, input bit cancel_in_issue);
        bit ok;
        int chg;
        sel_valid = 1'b1;
        sel_code  = 3'(code);
        if (with_coin) begin
            coin_valid = 1'b1;
            coin_value = 4'd1;
        end
        tick();
        idle_inputs();
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_money", 32'(core_if.core_money), 32'(m_credit));
        chk("issue_code", 32'(core_if.core_code), 32'(code));
        chk("issue_coin_reject", 32'(coin_reject), 32'(with_coin));
        chk("issue_state", 32'(state_dbg), 32'(ST_ISSUE));
        if (cancel_in_issue) cancel = 1'b1;
        tick();
        idle_inputs();
        chk("wait_money", 32'(core_if.core_money), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_code", 32'(core_if.core_code), 32'(code));
        ok = 1'b0;
        if (code < NUM_PRODUCTS) ok = (m_stock[code] > 0) && (m_credit >= price[code]);
        chg = 0;
        if (ok) begin
            chg = m_credit - price[code];
            m_stock[code]--;
            m_credit = 0;
        end
        tick();
        chk("res_done", 32'(vend_done), 32'(ok));
        chk("res_fail", 32'(vend_fail), 32'(!ok));
        chk("res_refund_valid", 32'(refund_valid), 32'(chg != 0));
        chk("res_refund_amount", 32'(refund_amount), 32'(chg));
        chk("res_credit", 32'(credit), 32'(m_credit));
        chk("res_busy", 32'(busy), 32'd0);
        tick();
        chk("post_strobes", {29'd0, vend_done, vend_fail, refund_valid}, 32'd0);
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        idle_inputs();
        chk("cancel_refund_valid", 32'(refund_valid), 32'd1);
        chk("cancel_refund_amount", 32'(refund_amount), 32'(m_credit));
        chk("cancel_busy", 32'(busy), 32'd1);
        m_credit = 0;
        tick();
        chk("cancel_after_valid", 32'(refund_valid), 32'd0);
        chk("cancel_after_credit", 32'(credit), 32'd0);
        chk("cancel_after_state", 32'(state_dbg), 32'(ST_IDLE));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_credit"}, 32'(credit), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_strobes"}, {28'd0, vend_done, vend_fail, refund_valid, coin_reject}, 32'd0);
        chk({tag, "_refund_amount"}, 32'(refund_amount), 32'd0);
        chk({tag, "_money"}, 32'(core_if.core_money), 32'd0);
        chk({tag, "_code"}, 32'(core_if.core_code), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit must_clear;
        reset = 1'b1;
        idle_inputs();
        tick();
        check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("post_reset");

        // 5+5+5, buy product 2 (price 10): change 5
        do_coin(5);
        do_coin(5);
        do_coin(5);
        do_select(2, 1'b0, 1'b0);

        // product 1 out of stock: fail keeps credit, then cancel refunds
        do_coin(10);
        do_select(1, 1'b0, 1'b0);
        do_cancel();

        // overflowing coin rejected; coin alongside select rejected, vend goes on
        do_coin(10);
        do_coin(10);
        do_select(3, 1'b1, 1'b0);

        // short credit fails, topping up succeeds with exact money
        do_coin(5);
        do_select(0, 1'b0, 1'b0);
        do_coin(10);
        do_select(0, 1'b0, 1'b0);

        // cancel during ISSUE is ignored
        do_coin(3);
        do_select(4, 1'b0, 1'b1);

        // invalid code comes back as a failure
        do_coin(4);
        do_select(6, 1'b0, 1'b0);
        do_cancel();

        // inactivity timeout refunds credit
        do_coin(5);
        for (int k = 2; k <= TMO; k++) begin
            tick();
            chk("tmo_quiet", 32'(refund_valid), 32'd0);
        end
        tick();
        chk("tmo_refund_valid", 32'(refund_valid), 32'd1);
        chk("tmo_refund_amount", 32'(refund_amount), 32'd5);
        m_credit = 0;
        tick();
        chk("tmo_after_credit", 32'(credit), 32'd0);
        chk("tmo_after_state", 32'(state_dbg), 32'(ST_IDLE));

        // a coin at idle cycle 6 restarts the count
        do_coin(5);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("tmo2_quiet_a", 32'(refund_valid), 32'd0);
        end
        tick();
        do_coin(1);
        for (int k = 2; k <= TMO; k++) begin
            tick();
            chk("tmo2_quiet_b", 32'(refund_valid), 32'd0);
        end
        tick();
        chk("tmo2_refund_valid", 32'(refund_valid), 32'd1);
        chk("tmo2_refund_amount", 32'(refund_amount), 32'd6);
        m_credit = 0;
        tick();

        // reset in WAIT clears everything at once
        do_coin(10);
        sel_valid = 1'b1;
        sel_code  = 3'd3;
        tick();
        idle_inputs();
        tick();
        chk("rst_in_wait", 32'(state_dbg), 32'(ST_WAIT));
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        m_stock[3]--;
        m_credit = 0;
        tick();
        reset = 1'b0;
        do_coin(5);
        do_cancel();

        // random session mix
        must_clear = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int r;
            int v;
            if (m_credit == 0) begin
                do_coin($urandom_range(1, 15));
                must_clear = 1'b0;
            end else begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    v = $urandom_range(1, 15);
                    if (must_clear && (m_credit + v > CMAX)) begin
                        do_cancel();
                        must_clear = 1'b0;
                    end else begin
                        must_clear = (m_credit + v > CMAX);
                        do_coin(v);
                    end
                end else if (r < 9) begin
                    do_select($urandom_range(0, 7), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 3) == 0));
                    must_clear = (m_credit != 0);
                end else begin
                    do_cancel();
                    must_clear = 1'b0;
                end
            end
        end
        if (m_credit != 0) do_cancel();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_session_ctrl.md
Name: vend_session_ctrl

Overview:
Customer-session sequencer in front of the existing vending core, which has registered dispense, change and out_of_stock outputs and samples money and product code every clock.
- Accumulates coin credit and latches the product selection.
- Presents money and code to the core for exactly one cycle per purchase, then samples the core's registered result.
- Reports the outcome and returns change or refunds. Handles cancel and inactivity timeout.
- Keeps the core's money input at 0 at all other times, so the core never decrements stock outside an issued request.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before an automatic refund (must be >= 2)
CREDIT_MAX, 15, maximum credit held; must fit in 4 bits to match the core's money width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
coin_valid  in  1  one-cycle coin-insert strobe
coin_value  in  4  value of the inserted coin
sel_valid  in  1  one-cycle product-select strobe
sel_code  in  3  product code
cancel  in  1  one-cycle refund request
core_money  out  4  money presented to the core; 0 except in ISSUE
core_code  out  3  product code presented to the core; the latched selection
core_dispense  in  1  core's registered dispense output
core_change  in  4  core's registered change output
core_oos  in  1  core's registered out_of_stock output
credit  out  4  current credit
busy  out  1  high in ISSUE, WAIT or REFUND
vend_done  out  1  one-cycle strobe: product dispensed
vend_fail  out  1  one-cycle strobe: out of stock, invalid code, or insufficient credit
refund_valid  out  1  one-cycle strobe: coins returned
refund_amount  out  4  amount returned; valid with refund_valid, otherwise 0
coin_reject  out  1  one-cycle strobe: coin not accepted, credit unchanged

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; credit 0; timer 0; latched code 0. Credit held at reset is lost; this is accepted and documented.
- States: IDLE (credit 0), CREDIT, ISSUE, WAIT, REFUND.
- Coin handling in IDLE/CREDIT:
  - Form a 5-bit sum of credit + coin_value.
  - If sum <= CREDIT_MAX: credit = sum, go to CREDIT, timer cleared.
  - Otherwise: coin_reject pulses next cycle and credit is unchanged.
  - A coin_value of 0 is accepted as a no-op and clears the timer.
- Coins arriving in ISSUE/WAIT/REFUND, or in the same cycle as an accepted sel_valid or cancel, are rejected (coin_reject=1).
- IDLE: sel_valid and cancel are ignored; no strobes.
- CREDIT priority, highest first:
  - cancel -> REFUND.
  - sel_valid -> latch sel_code -> ISSUE.
  - coin (per the rules above).
  - Timer reaching TIMEOUT_CYCLES-1 with no activity -> REFUND.
- The timer counts only in CREDIT and clears on any accepted coin or selection.
- ISSUE (exactly 1 cycle): core_money=credit, core_code=latched code -> WAIT.
- WAIT (exactly 1 cycle): core_money=0, core_code held; the core's registered result is valid this cycle and is sampled.
  - core_dispense=1: vend_done pulse next cycle. If core_change != 0, also refund_valid with refund_amount=core_change. Credit -> 0, go to IDLE.
  - core_oos=1, or neither flag set: vend_fail pulse next cycle; credit retained; go to CREDIT with the timer cleared.
- REFUND (1 cycle): refund_valid=1, refund_amount=credit; credit -> 0; go to IDLE.
- Latency: selection strobe at cycle T -> ISSUE at T+1 -> WAIT at T+2 -> vend_done/vend_fail at T+3.
- sel_code values 6 and 7 are passed to the core unmodified; the core's out_of_stock response produces vend_fail.
- cancel during ISSUE/WAIT is ignored. The transaction completes, and any credit retained afterwards must be cancelled again.
- All strobes are registered and last exactly one cycle.

Decomposition:
- Shared package vend_pkg: state enumeration; CREDIT_W=4; CODE_W=3; NUM_PRODUCTS=6.
- One sub-module: vend_timeout_timer, a counter with clear and enable inputs and a terminal-count output parameterised by TIMEOUT_CYCLES.

Test Plan:
- Coins 5,5,5 then sel 2 (price 10, stock 3) -> ISSUE shows core_money=15, core_code=2; vend_done 3 cycles after sel; refund_valid with refund_amount=5; credit 0.
- Coin 10 then sel 1 (stock 0) -> vend_fail, credit stays 10, no refund_valid; then cancel -> refund_valid with refund_amount=10, credit 0, state IDLE.
- Credit 10 then coin 10 -> coin_reject=1, credit stays 10. Coin and sel in the same cycle -> coin_reject=1 and the vend proceeds.
- Credit 5, sel 0 (price 15) -> vend_fail, credit 5. Then coin 10 and sel 0 -> vend_done with no refund_valid (change 0).
- TIMEOUT_CYCLES=8, credit 5, no activity -> refund_valid with refund_amount=5 on the 8th idle cycle. Also check that a coin at idle cycle 6 restarts the count.
- Assert reset during WAIT -> all outputs 0 immediately, credit 0, core_money 0, state IDLE; the next coin behaves normally.
